// File: rtl/spi_master_sequencer.sv
// Byte-oriented SPI master (mode 0, MSB first) that frames
// multi-byte messages under one SSEL assertion.
module spi_master_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             SCK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             SSEL
);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, SHIFT, HOLD
  } state_e;

  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             done_q, done_d;
  logic             sck_q, sck_d;
  logic             ssel_q, ssel_d;
  logic             miso_meta_q, miso_sync_q;
  logic             div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    rem_d      = rem_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    sck_d      = sck_q;
    ssel_d     = ssel_q;
    if (abort && state_q != IDLE) begin
      // abort beats everything, including a byte completing this cycle
      state_d = IDLE;
      div_d   = '0;
      bit_d   = '0;
      rem_d   = '0;
      tx_sr_d = '0;
      sck_d   = 1'b0;
      ssel_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && len != '0) begin
            rem_d   = len;
            div_d   = '0;
            ssel_d  = 1'b0;
            state_d = SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_d   = '0;
            state_d = LOAD;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        LOAD: begin
          if (tx_valid) begin
            tx_sr_d = tx_data;
            bit_d   = '0;
            div_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_d = div_q + 8'd1;
          end else begin
            div_d = '0;
            if (!sck_q) begin
              sck_d   = 1'b1;
              rx_sr_d = {rx_sr_q[6:0], miso_sync_q};
            end else begin
              sck_d   = 1'b0;
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
                rem_d      = rem_q - REM_ONE;
                state_d    = (rem_q == REM_ONE) ? HOLD : LOAD;
              end
            end
          end
        end
        HOLD: begin
          if (div_end) begin
            div_d   = '0;
            ssel_d  = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      rem_q       <= rem_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  // MOSI is the shift register MSB, so it is set a full half-period before each rise
  assign MOSI     = tx_sr_q[7];
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign busy     = (state_q != IDLE);
  assign tx_ready = (state_q == LOAD);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign done     = done_q;

endmodule
